// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode, funct, ALU code and mux encodings for the multicycle MIPS control
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps an R-type Funct field to an ALU code and flags unsupported functs
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_illegal
);
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS FSM sequencing fetch/decode/execute/memory/writeback
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       IllegalOp
);
  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_fn_op;
  logic       w_fn_bad;
  alu_decoder u_alu_decoder (
    .i_funct  (Funct),
    .o_alu_op (w_fn_op),
    .o_illegal(w_fn_bad)
  );
  always_ff @(posedge clk)
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  always_comb begin
    w_next    = S_FETCH;
    PCEn      = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_B;
    PCSource  = PCSRC_ALU;
    ALUOp     = ALU_AND;
    IllegalOp = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        ALUOp   = ALU_ADD;
        IRWrite = MemReady;
        PCEn    = MemReady;
        w_next  = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_IMMSH;
        ALUOp     = ALU_ADD;
        w_next    = (Op == OP_RTYPE) ? S_RTYPEEX :
                    (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
                    (Op == OP_BEQ) ? S_BEQEX :
                    (Op == OP_ADDI) ? S_ADDIEX :
                    (Op == OP_J) ? S_JEX : S_FETCH;
        IllegalOp = (w_next == S_FETCH);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        w_next  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = MemReady ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        ALUSrcA   = 1'b1;
        ALUOp     = w_fn_op;
        IllegalOp = w_fn_bad;
        w_next    = w_fn_bad ? S_FETCH : S_RTYPEWB;
      end
      S_RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQEX: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCSRC_ALUOUT;
        PCEn     = Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JEX: begin
        PCSource = PCSRC_JUMP;
        PCEn     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset silences every strobe so an abandoned instruction cannot write anything
    if (!rst_n) begin
      PCEn      = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      MemtoReg  = 1'b0;
      RegDst    = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_B;
      PCSource  = PCSRC_ALU;
      ALUOp     = ALU_AND;
      IllegalOp = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: per-cycle vector table plus hand-written illegal-funct and mid-instruction reset sequences
module tb_mips_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] fn = '0;
  logic       zero = 1'b0;
  logic       rdy = 1'b1;
  logic       pcen, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
  logic [1:0] sb, ps;
  logic [2:0] aop;
  int         n_run = 0;
  int         n_fail = 0;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  typedef struct {
    logic        r;
    logic        m;
    logic [5:0]  o;
    logic [5:0]  f;
    logic        z;
    logic [16:0] e;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(fn), .Zero(zero), .MemReady(rdy),
    .PCEn(pcen), .IorD(iord), .MemRead(mrd), .MemWrite(mwr), .IRWrite(irw),
    .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(sa), .ALUSrcB(sb),
    .PCSource(ps), .ALUOp(aop), .IllegalOp(ill)
  );
  // Packed order: PCEn IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB PCSource ALUOp IllegalOp
  function automatic logic [16:0] o(input logic a, b, c, d, e, f, g, h, i,
                                    input logic [1:0] j, k, input logic [2:0] l, input logic m);
    return {a, b, c, d, e, f, g, h, i, j, k, l, m};
  endfunction
  function automatic logic [16:0] e_fetch(input logic r);  return o(r,0,1,0,r,0,0,0,0,2'b01,2'b00,3'b010,0); endfunction
  function automatic logic [16:0] e_dec(input logic b);    return o(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,b); endfunction
  function automatic logic [16:0] e_madr();                return o(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0); endfunction
  function automatic logic [16:0] e_mrd();                 return o(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0); endfunction
  function automatic logic [16:0] e_mwb();                 return o(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0); endfunction
  function automatic logic [16:0] e_mwr();                 return o(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0); endfunction
  function automatic logic [16:0] e_rex(input logic [2:0] a, input logic b); return o(0,0,0,0,0,0,0,0,1,2'b00,2'b00,a,b); endfunction
  function automatic logic [16:0] e_rwb();                 return o(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0); endfunction
  function automatic logic [16:0] e_beq(input logic z);    return o(z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0); endfunction
  function automatic logic [16:0] e_aex();                 return o(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0); endfunction
  function automatic logic [16:0] e_awb();                 return o(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0); endfunction
  function automatic logic [16:0] e_jex();                 return o(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0); endfunction
  task automatic add(input logic r, m, input logic [5:0] a, f, input logic z, input logic [16:0] e);
    tv.push_back('{r, m, a, f, z, e});
  endtask
  task automatic step(input int id, input logic r, m, input logic [5:0] a, f,
                      input logic z, input logic [16:0] e);
    logic [16:0] got;
    rst_n = r; rdy = m; op = a; fn = f; zero = z;
    @(negedge clk);
    got = {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, aop, ill};
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL step%0d outputs got %b required %b", id, got, e);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] fns [4];
    logic [2:0] ops [4];
    fns = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    ops = '{3'b010, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 3; i++) add(0, 1, LW, 0, 0, '0);
    add(1, 1, LW, 0, 0, e_fetch(1));
    add(1, 1, LW, 0, 0, e_dec(0));
    add(1, 1, LW, 0, 0, e_madr());
    add(1, 1, LW, 0, 0, e_mrd());
    add(1, 1, LW, 0, 0, e_mwb());
    for (int i = 0; i < 3; i++) add(1, 0, RT, 6'b100010, 0, e_fetch(0));
    add(1, 1, RT, 6'b100010, 0, e_fetch(1));
    add(1, 1, RT, 6'b100010, 0, e_dec(0));
    add(1, 1, RT, 6'b100010, 0, e_rex(3'b110, 0));
    add(1, 1, RT, 6'b100010, 0, e_rwb());
    add(1, 1, BEQ, 0, 1, e_fetch(1));
    add(1, 1, BEQ, 0, 1, e_dec(0));
    add(1, 1, BEQ, 0, 1, e_beq(1));
    add(1, 1, BEQ, 0, 0, e_fetch(1));
    add(1, 1, BEQ, 0, 0, e_dec(0));
    add(1, 1, BEQ, 0, 0, e_beq(0));
    add(1, 1, ADDI, 0, 0, e_fetch(1));
    add(1, 1, ADDI, 0, 0, e_dec(0));
    add(1, 1, ADDI, 0, 0, e_aex());
    add(1, 1, ADDI, 0, 0, e_awb());
    add(1, 1, J, 0, 0, e_fetch(1));
    add(1, 1, J, 0, 0, e_dec(0));
    add(1, 1, J, 0, 0, e_jex());
    add(1, 1, SW, 0, 0, e_fetch(1));
    add(1, 1, SW, 0, 0, e_dec(0));
    add(1, 1, SW, 0, 0, e_madr());
    add(1, 0, SW, 0, 0, e_mwr());
    add(1, 1, SW, 0, 0, e_mwr());
    add(1, 1, LW, 0, 0, e_fetch(1));
    add(1, 1, LW, 0, 0, e_dec(0));
    add(1, 1, LW, 0, 0, e_madr());
    add(1, 0, LW, 0, 0, e_mrd());
    add(1, 1, LW, 0, 0, e_mrd());
    add(1, 1, LW, 0, 0, e_mwb());
    for (int i = 0; i < 4; i++) begin
      add(1, 1, RT, fns[i], 0, e_fetch(1));
      add(1, 1, RT, fns[i], 0, e_dec(0));
      add(1, 1, RT, fns[i], 0, e_rex(ops[i], 0));
      add(1, 1, RT, fns[i], 0, e_rwb());
    end
    add(1, 1, BAD, 0, 0, e_fetch(1));
    add(1, 1, BAD, 0, 0, e_dec(1));
    foreach (tv[i]) step(i, tv[i].r, tv[i].m, tv[i].o, tv[i].f, tv[i].z, tv[i].e);
    // Illegal funct: one IllegalOp pulse, straight back to fetch without writeback
    step(100, 1, 1, RT, BAD, 0, e_fetch(1));
    step(101, 1, 1, RT, BAD, 0, e_dec(0));
    step(102, 1, 1, RT, BAD, 0, e_rex(3'b010, 1));
    step(103, 1, 1, RT, BAD, 0, e_fetch(1));
    step(104, 1, 1, RT, BAD, 0, e_dec(0));
    step(105, 1, 1, RT, BAD, 0, e_rex(3'b010, 1));
    // Reset while a store is stalled in the memory-write state
    step(200, 1, 1, SW, 0, 0, e_fetch(1));
    step(201, 1, 1, SW, 0, 0, e_dec(0));
    step(202, 1, 1, SW, 0, 0, e_madr());
    step(203, 1, 0, SW, 0, 0, e_mwr());
    step(204, 0, 0, SW, 0, 0, '0);
    step(205, 0, 0, SW, 0, 0, '0);
    step(206, 1, 0, SW, 0, 0, e_fetch(0));
    step(207, 1, 1, SW, 0, 0, e_fetch(1));
    step(208, 1, 1, SW, 0, 0, e_dec(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle MIPS control unit. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and muxes. It sits directly upstream of the ALU: it produces the 3-bit `ALUOp` code the ALU consumes, and it samples the ALU's `Zero` flag to resolve `beq`. It supports the R-type add/sub/and/or/slt, `lw`, `sw`, `beq`, `addi` and `j` instructions, and stalls on a memory-ready handshake.

## Interface
Parameters: none.

- `clk` input 1: system clock; all state changes on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `Op` input 6: instruction opcode, taken from the instruction register (IR[31:26]).
- `Funct` input 6: R-type function field, taken from IR[5:0].
- `Zero` input 1: ALU zero flag.
- `MemReady` input 1: memory completes the current read or write this cycle.
- `PCEn` output 1: PC register write enable.
- `IorD` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `MemRead` output 1: memory read request.
- `MemWrite` output 1: memory write request.
- `IRWrite` output 1: instruction register load.
- `MemtoReg` output 1: register-file write data; 0 = ALUOut, 1 = MDR.
- `RegDst` output 1: destination register; 0 = rt, 1 = rd.
- `RegWrite` output 1: register-file write enable.
- `ALUSrcA` output 1: ALU A input; 0 = PC, 1 = register A.
- `ALUSrcB` output 2: ALU B input; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `PCSource` output 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp` output 3: direct ALU code; 000 and, 001 or, 010 add, 110 sub, 111 slt.
- `IllegalOp` output 1: one-cycle pulse when an unsupported Op or Funct is decoded.

## Operation
- States:
  - S_FETCH
  - S_DECODE
  - S_MEMADR
  - S_MEMRD
  - S_MEMWB
  - S_MEMWR
  - S_RTYPEEX
  - S_RTYPEWB
  - S_BEQEX
  - S_ADDIEX
  - S_ADDIWB
  - S_JEX
- S_FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00.
  - IRWrite=PCEn=MemReady.
  - Holds while MemReady=0; moves to S_DECODE when MemReady=1.
- S_DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=010, precomputing the branch target into ALUOut.
  - Next state by Op:
    - 000000 → S_RTYPEEX
    - 100011 or 101011 → S_MEMADR
    - 000100 → S_BEQEX
    - 001000 → S_ADDIEX
    - 000010 → S_JEX
    - any other Op → S_FETCH, with IllegalOp=1 this cycle.
- S_MEMADR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=010.
  - Goes to S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD:
  - Drives MemRead=1, IorD=1.
  - Holds until MemReady, then goes to S_MEMWB.
- S_MEMWB:
  - Drives RegWrite=1, MemtoReg=1, RegDst=0.
  - Goes to S_FETCH.
- S_MEMWR:
  - Drives MemWrite=1, IorD=1.
  - Holds until MemReady, then goes to S_FETCH.
- S_RTYPEEX:
  - Drives ALUSrcA=1, ALUSrcB=00.
  - ALUOp by Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Unsupported Funct: ALUOp=010, IllegalOp=1, next state S_FETCH (no writeback).
  - Otherwise next state S_RTYPEWB.
- S_RTYPEWB:
  - Drives RegWrite=1, RegDst=1, MemtoReg=0.
  - Goes to S_FETCH.
- S_BEQEX:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCSource=01.
  - PCEn=Zero.
  - Goes to S_FETCH.
- S_ADDIEX:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=010.
  - Goes to S_ADDIWB.
- S_ADDIWB:
  - Drives RegWrite=1, RegDst=0, MemtoReg=0.
  - Goes to S_FETCH.
- S_JEX:
  - Drives PCSource=10, PCEn=1.
  - Goes to S_FETCH.
- Default values: any output not listed for a state is 0 in that state.

## Timing
- State transitions occur on the rising edge of `clk`.
- Outputs are combinational from the state register. IRWrite and PCEn additionally depend on the MemReady and Zero inputs in the same cycle.
- Reset:
  - With rst_n=0 at an edge, state becomes S_FETCH.
  - While rst_n=0, all outputs are forced to 0, including PCEn, MemRead, MemWrite and IllegalOp.
  - Reset mid-instruction abandons the instruction; no partial writeback occurs after reset is sampled.
- Cycle counts with MemReady tied to 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each cycle with MemReady=0 in S_FETCH, S_MEMRD or S_MEMWR adds one cycle. Outputs stay stable during the stall.
- IllegalOp is asserted for exactly one cycle per illegal instruction.
- `Op` and `Funct` must stay stable from S_DECODE until the next S_FETCH; the IR is not rewritten in that window.

## Structure
- Shared package `mips_pkg` holds:
  - state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU code constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111
  - ALUSrcB and PCSource encodings
- One natural sub-module, `alu_decoder`: combinational Funct→ALUOp mapping plus an illegal-Funct flag. It is instantiated once and consulted in S_RTYPEEX.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all outputs 0. Release with MemReady=1 → cycle 1 in S_FETCH with MemRead=1, IRWrite=1, PCEn=1, ALUOp=010.
- lw (Op=100011), MemReady=1 → 5 cycles. RegWrite=1 with MemtoReg=1 in cycle 5 only. Then back in S_FETCH.
- Fetch stall: MemReady=0 for 3 cycles in S_FETCH → IRWrite=PCEn=0 throughout, state holds. MemReady=1 → IRWrite=1 that cycle, S_DECODE next.
- R-type:
  - Funct=100010 → ALUOp=110 in S_RTYPEEX; RegWrite=1, RegDst=1 next cycle.
  - Funct=111111 → IllegalOp=1 for one cycle, RegWrite never asserted, return to S_FETCH.
- beq (Op=000100):
  - Zero=1 → PCEn=1, PCSource=01 in cycle 3.
  - Zero=0 → PCEn=0 in cycle 3.
- Reset mid-instruction: drop rst_n in S_MEMWR with MemReady=0 → MemWrite=0 while reset is low, S_FETCH after release, no RegWrite pulse.
